// File: rtl/peak_capture_pkg.sv
// Shared types and constants for the peak capture block and its trigger helpers.
// The state enum is exported so debug/observation logic can decode the FSM.
package peak_capture_pkg;

  localparam int WIDTH_DEF    = 12;
  localparam int TS_WIDTH_DEF = 32;
  localparam int LEN_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/peak_capture_rise_detect.sv
// Rising-edge detector: one register holding the previous input level.
// The register clears on reset, so a level already high after release is an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/peak_capture.sv
// Captures the signed maximum of a triggered window of N+1 samples together with
// its first-occurrence offset and the trigger timestamp, then holds it as an event.
//
// Event handshake: evt_valid stays high with evt_* stable until a cycle in which
// evt_valid and evt_ready are both high; that cycle transfers the record.
module peak_capture
  import peak_capture_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trig_in,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0]        window_len,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic signed [WIDTH-1:0] evt_peak,
  output logic [LEN_W-1:0]        evt_offset,
  output logic [TS_WIDTH-1:0]     evt_time,
  output logic                    busy,
  output logic [LEN_W-1:0]        lost_count,
  output state_t                  dbg_state
);

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_rise;
  logic                    w_accept;
  logic                    w_lost;
  logic                    w_last_sample;
  logic [LEN_W-1:0]        w_idx;
  logic [TS_WIDTH-1:0]     r_ts;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_elapsed;
  logic signed [WIDTH-1:0] r_peak;
  logic [LEN_W-1:0]        r_offset;
  logic [TS_WIDTH-1:0]     r_time;
  logic [LEN_W-1:0]        r_lost_count;

  rise_detect u_rise_detect (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (trig_in),
    .o_rise (w_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  // Index of the sample presented this cycle while in CAPTURE (1..N).
  // r_elapsed never exceeds N-1 here, so the 16-bit sum cannot overflow.
  assign w_idx         = r_elapsed + LEN_W'(1);
  assign w_last_sample = (w_idx == r_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_next_state = (window_len == '0) ? ST_HOLD : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_last_sample) begin
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (evt_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    evt_valid = 1'b0;
    busy      = 1'b1;
    w_accept  = 1'b0;
    w_lost    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy     = 1'b0;
        w_accept = w_rise;
      end
      ST_CAPTURE: begin
        w_lost = w_rise;
      end
      ST_HOLD: begin
        evt_valid = 1'b1;
        w_lost    = w_rise;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Window datapath: sample 0 is latched at acceptance, later samples replace the
  // peak only when strictly larger, which keeps the earliest of equal maxima.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len     <= '0;
      r_elapsed <= '0;
      r_peak    <= '0;
      r_offset  <= '0;
      r_time    <= '0;
    end else if (w_accept) begin
      r_len     <= window_len;
      r_elapsed <= '0;
      r_peak    <= data_in;
      r_offset  <= '0;
      r_time    <= r_ts;
    end else if (r_state == ST_CAPTURE) begin
      r_elapsed <= w_idx;
      if (data_in > r_peak) begin
        r_peak   <= data_in;
        r_offset <= w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lost_count <= '0;
    end else if (w_lost) begin
      r_lost_count <= sat_inc(r_lost_count);
    end
  end

  assign evt_peak   = r_peak;
  assign evt_offset = r_offset;
  assign evt_time   = r_time;
  assign lost_count = r_lost_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_peak_capture.sv
// Bench for peak_capture: directed vector table, hand-written corner sequences and
// randomized windows checked against a simple max/first-index reference model.
module tb_peak_capture;
  import peak_capture_pkg::*;

  localparam int W   = 12;
  localparam int TSW = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic                trig_in;
  logic signed [W-1:0] data_in;
  logic [15:0]         window_len;
  logic                evt_valid;
  logic                evt_ready;
  logic signed [W-1:0] evt_peak;
  logic [15:0]         evt_offset;
  logic [TSW-1:0]      evt_time;
  logic                busy;
  logic [15:0]         lost_count;
  state_t              dbg_state;

  peak_capture #(.WIDTH(W), .TS_WIDTH(TSW)) dut (
    .clk        (clk),
    .reset      (reset),
    .trig_in    (trig_in),
    .data_in    (data_in),
    .window_len (window_len),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_peak   (evt_peak),
    .evt_offset (evt_offset),
    .evt_time   (evt_time),
    .busy       (busy),
    .lost_count (lost_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset / timestamp model ----------------
  always #5 clk = ~clk;

  logic [TSW-1:0] tb_ts;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int   errors = 0;
  int   checks = 0;
  int   exp_lost;
  logic tb_prev;
  int   smp[$];
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk_peak(input string name, input int exp);
    logic signed [W-1:0] e;
    e = W'(exp);
    checks++;
    if (evt_peak !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, evt_peak, e, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    tb_prev = trig_in;
    @(posedge clk);
    #1;
  endtask

  task automatic bump_lost();
    if (trig_in && !tb_prev && exp_lost < 65535) exp_lost++;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    trig_in    = 1'b0;
    evt_ready  = 1'b0;
    data_in    = '0;
    window_len = '0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    tb_prev  = 1'b0;
    exp_lost = 0;
  endtask

  // Reference: value of the maximum sample, then the first index holding it.
  task automatic model(output int pk, output int off);
    pk = smp[0];
    foreach (smp[i]) if (smp[i] > pk) pk = smp[i];
    off = -1;
    foreach (smp[i]) if (off < 0 && smp[i] == pk) off = i;
  endtask

  // Trigger in the current cycle and stream smp[1..n]; returns in cycle T+N+1.
  task automatic capture(input int n, input bit noisy, output logic [TSW-1:0] t0);
    if (tb_prev) begin
      trig_in = 1'b0;
      tick();
    end
    trig_in    = 1'b1;
    data_in    = W'(smp[0]);
    window_len = 16'(n);
    t0         = tb_ts;
    tick();
    for (int i = 1; i <= n; i++) begin
      chk("valid_low_capture", 32'(evt_valid), 32'd0);
      chk("busy_capture", 32'(busy), 32'd1);
      trig_in    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bump_lost();
      data_in    = W'(smp[i]);
      window_len = 16'($urandom);
      tick();
    end
    trig_in = trig_in & noisy;
    chk("valid_high_hold", 32'(evt_valid), 32'd1);
    chk("state_hold", 32'(dbg_state), 32'(ST_HOLD));
  endtask

  task automatic check_event(input int pk, input int off, input logic [TSW-1:0] t0);
    chk_peak("evt_peak", pk);
    chk("evt_offset", 32'(evt_offset), 32'(off));
    chk("evt_time", evt_time, t0);
  endtask

  task automatic hold_wait(input int cycles, input int pk, input int off, input logic [TSW-1:0] t0,
                           input bit rand_trig, input logic [15:0] pattern);
    for (int c = 0; c < cycles; c++) begin
      trig_in = rand_trig ? 1'($urandom_range(0, 1)) : pattern[c];
      bump_lost();
      chk("valid_stable", 32'(evt_valid), 32'd1);
      check_event(pk, off, t0);
      tick();
    end
  endtask

  task automatic handshake(input logic trig_v);
    trig_in   = trig_v;
    bump_lost();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("valid_after_hs", 32'(evt_valid), 32'd0);
    chk("busy_after_hs", 32'(busy), 32'd0);
    chk("lost_count", 32'(lost_count), 32'(exp_lost));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int n;
    int s[6];
    int at_ts;
    int exp_peak;
    int exp_off;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [TSW-1:0] t0;
    int pk, off;

    vecs[0] = '{n: 4, s: '{10, 50, -3, 50, 20, 0},  at_ts: 100, exp_peak: 50,    exp_off: 1};
    vecs[1] = '{n: 0, s: '{-2048, 0, 0, 0, 0, 0},   at_ts: -1,  exp_peak: -2048, exp_off: 0};
    vecs[2] = '{n: 2, s: '{-5, -1, -7, 0, 0, 0},    at_ts: -1,  exp_peak: -1,    exp_off: 1};

    do_reset();
    chk("reset_valid", 32'(evt_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_lost", 32'(lost_count), 32'd0);
    chk("reset_peak", 32'(evt_peak), 32'd0);
    chk("reset_offset", 32'(evt_offset), 32'd0);
    chk("reset_time", evt_time, 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    for (int v = 0; v < 3; v++) begin
      smp.delete();
      for (int i = 0; i <= vecs[v].n; i++) smp.push_back(vecs[v].s[i]);
      if (vecs[v].at_ts >= 0) begin
        for (int k = 0; k < 300 && tb_ts != TSW'(vecs[v].at_ts); k++) tick();
      end
      capture(vecs[v].n, 1'b0, t0);
      chk_peak("vec_peak", vecs[v].exp_peak);
      chk("vec_offset", 32'(evt_offset), 32'(vecs[v].exp_off));
      if (vecs[v].at_ts >= 0) chk("vec_time", evt_time, 32'(vecs[v].at_ts));
      else                    chk("vec_time", evt_time, t0);
      handshake(1'b0);
    end

    // Held event with three trigger edges while evt_ready is low.
    do_reset();
    repeat (3) tick();
    smp = '{7, -100, 300, 300};
    model(pk, off);
    capture(3, 1'b0, t0);
    check_event(pk, off, t0);
    hold_wait(10, pk, off, t0, 1'b0, 16'b0000_0001_0101);
    chk("lost_three", 32'(lost_count), 32'd3);
    handshake(1'b0);
    trig_in = 1'b0;
    tick();
    smp = '{-9, 12};
    model(pk, off);
    capture(1, 1'b0, t0);
    check_event(pk, off, t0);
    chk("lost_unchanged", 32'(lost_count), 32'd3);
    handshake(1'b0);

    // Reset in the middle of a capture discards the event.
    do_reset();
    repeat (5) tick();
    trig_in    = 1'b1;
    data_in    = 12'sd33;
    window_len = 16'd8;
    tick();
    trig_in = 1'b0;
    data_in = 12'sd500;
    tick();
    reset = 1'b1;
    #1;
    chk("midreset_valid", 32'(evt_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_peak", 32'(evt_peak), 32'd0);
    chk("midreset_offset", 32'(evt_offset), 32'd0);
    chk("midreset_time", evt_time, 32'd0);
    chk("midreset_lost", 32'(lost_count), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    tb_prev  = 1'b0;
    exp_lost = 0;
    for (int c = 0; c < 12; c++) begin
      chk("post_reset_idle", 32'({evt_valid, busy}), 32'd0);
      tick();
    end
    smp = '{4, 4, 9, -1, 9};
    model(pk, off);
    capture(4, 1'b0, t0);
    check_event(pk, off, t0);
    handshake(1'b0);

    // Saturation of the lost counter, preloaded close to the top.
    smp = '{1, 2};
    capture(1, 1'b0, t0);
    force dut.r_lost_count = 16'hFFFC;
    #1;
    release dut.r_lost_count;
    exp_lost = 32'hFFFC;
    hold_wait(16, 2, 1, t0, 1'b0, 16'b0101_0101_0101_0101);
    chk("lost_saturated", 32'(lost_count), 32'hFFFF);
    handshake(1'b1);
    chk("lost_stays_sat", 32'(lost_count), 32'hFFFF);

    // Randomized windows against the reference model.
    do_reset();
    for (int e = 0; e < 30; e++) begin
      int n;
      bit narrow;
      n = $urandom_range(0, 12);
      narrow = 1'($urandom_range(0, 1));
      smp.delete();
      for (int i = 0; i <= n; i++) begin
        smp.push_back(narrow ? int'($urandom_range(0, 3)) - 2 : int'($urandom_range(0, 4095)) - 2048);
      end
      model(pk, off);
      exp_q.push_back(W'(pk));
      capture(n, 1'b1, t0);
      check_event(pk, off, t0);
      hold_wait($urandom_range(0, 4), pk, off, t0, 1'b1, 16'h0);
      chk_peak("rand_peak_queue", int'($signed(exp_q.pop_front())));
      handshake(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        trig_in = 1'b0;
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
